// File: rtl/top_pkg.sv
// Shared constants for the fetch/display datapath: segment table, PC step, ROM size.
package top_pkg;

  localparam int unsigned ROM_AW_DEFAULT = 8;
  localparam logic [31:0] PC_STEP = 32'd4;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import top_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_LUT[nibble];
  end

endmodule

// File: rtl/top.sv
// Fetch/display top: PC walks an internal ROM, the fetched word is scanned onto 8 hex digits.
module top
  import top_pkg::*;
#(
  parameter int unsigned SCAN_SHIFT = 0,
  parameter int unsigned ROM_AW     = ROM_AW_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] out7,
  output logic [7:0] en_out
);

  localparam int unsigned ScanW = SCAN_SHIFT + 3;

  logic [31:0]       pc_q;
  logic [ScanW-1:0]  scan_q;
  logic [ROM_AW-1:0] rom_idx;
  logic [7:0]        rom_byte;
  logic [31:0]       instr;
  logic [2:0]        digit;
  logic [3:0]        nibble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      scan_q <= '0;
    end else begin
      pc_q   <= pc_q + PC_STEP;
      scan_q <= scan_q + 1'b1;
    end
  end

  // ROM word i holds i[7:0] in every byte; byte lanes of the PC are ignored.
  always_comb begin
    rom_idx  = pc_q[ROM_AW+1:2];
    rom_byte = 8'(rom_idx);
    instr    = {4{rom_byte}};
  end

  always_comb begin
    digit  = scan_q[SCAN_SHIFT+2:SCAN_SHIFT];
    nibble = instr[{digit, 2'b00} +: 4];
    en_out = ~(8'b1 << digit);
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (out7)
  );

endmodule

// File: tb/tb_top.sv
// Directed table-driven bench for top, with a second instance using a slowed digit scan.
module tb_top;

  logic       clk;
  logic       reset;
  logic [6:0] out7, out7_s;
  logic [7:0] en_out, en_out_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  top dut (
    .clk    (clk),
    .reset  (reset),
    .out7   (out7),
    .en_out (en_out)
  );

  top #(.SCAN_SHIFT(2)) dut_s (
    .clk    (clk),
    .reset  (reset),
    .out7   (out7_s),
    .en_out (en_out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [7:0]  en;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, logic [31:0] p, logic [7:0] e, logic [6:0] s);
    vec_t v;
    v.cyc = c; v.pc = p; v.en = e; v.seg = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // cycle n after reset shows digit n%8 of word n; odd n shows n[7:4], even n shows n[3:0]
    vecs.push_back(mk(0,   32'h000, 8'hFE, 7'h40));
    vecs.push_back(mk(1,   32'h004, 8'hFD, 7'h40));
    vecs.push_back(mk(2,   32'h008, 8'hFB, 7'h24));
    vecs.push_back(mk(3,   32'h00C, 8'hF7, 7'h40));
    vecs.push_back(mk(4,   32'h010, 8'hEF, 7'h19));
    vecs.push_back(mk(5,   32'h014, 8'hDF, 7'h40));
    vecs.push_back(mk(6,   32'h018, 8'hBF, 7'h02));
    vecs.push_back(mk(7,   32'h01C, 8'h7F, 7'h40));
    vecs.push_back(mk(8,   32'h020, 8'hFE, 7'h00));
    vecs.push_back(mk(9,   32'h024, 8'hFD, 7'h40));
    vecs.push_back(mk(10,  32'h028, 8'hFB, 7'h08));
    vecs.push_back(mk(12,  32'h030, 8'hEF, 7'h46));
    vecs.push_back(mk(14,  32'h038, 8'hBF, 7'h06));
    vecs.push_back(mk(177, 32'h2C4, 8'hFD, 7'h03));
    vecs.push_back(mk(209, 32'h344, 8'hFD, 7'h21));
    vecs.push_back(mk(241, 32'h3C4, 8'hFD, 7'h0E));
    vecs.push_back(mk(255, 32'h3FC, 8'h7F, 7'h0E));
    vecs.push_back(mk(256, 32'h400, 8'hFE, 7'h40));
    vecs.push_back(mk(257, 32'h404, 8'hFD, 7'h40));

    reset = 1'b1;
    #1;
    check("reset_en", 32'(en_out), 32'hFE);
    check("reset_seg", 32'(out7), 32'h40);
    repeat (2) @(negedge clk);
    reset = 1'b0;  // released 5 ns after a rising edge
    #1;
    cyc = 0;

    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) step();
      check($sformatf("pc@%0d", cyc), dut.pc_q, vecs[i].pc);
      check($sformatf("en@%0d", cyc), 32'(en_out), 32'(vecs[i].en));
      check($sformatf("seg@%0d", cyc), 32'(out7), 32'(vecs[i].seg));
    end

    // Asynchronous reset mid-cycle, away from any edge.
    @(posedge clk);
    #2;
    check("pre_reset_pc_nonzero", 32'(dut.pc_q != 0), 32'd1);
    reset = 1'b1;
    #1;
    check("async_pc", dut.pc_q, 32'h0);
    check("async_en", 32'(en_out), 32'hFE);
    check("async_seg", 32'(out7), 32'h40);
    check("async_pc_s", dut_s.pc_q, 32'h0);
    check("async_cnt_s", 32'(dut_s.scan_q), 32'h0);
    check("async_en_s", 32'(en_out_s), 32'hFE);
    check("async_seg_s", 32'(out7_s), 32'h40);

    // Slow scan: digit holds 4 clocks while PC steps every clock.
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
    for (int n = 0; n < 6; n++) begin
      logic [6:0] exp_seg;
      unique case (n)
        0: exp_seg = 7'h40;
        1: exp_seg = 7'h79;
        2: exp_seg = 7'h24;
        3: exp_seg = 7'h30;
        default: exp_seg = 7'h40;
      endcase
      check($sformatf("slow_pc@%0d", n), dut_s.pc_q, 32'(4 * n));
      check($sformatf("slow_en@%0d", n), 32'(en_out_s), (n < 4) ? 32'hFE : 32'hFD);
      check($sformatf("slow_seg@%0d", n), 32'(out7_s), 32'(exp_seg));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
